// File: rtl/vga_mode_sequencer.sv
// VGA mode sequencer: debounced next-mode button plus optional auto-cycling,
// with mode commits deferred to frame boundaries and a blanked pixel mux.
module vga_mode_sequencer #(
  parameter int TOTAL_COL       = 800,
  parameter int TOTAL_ROW       = 525,
  parameter int ACTIVE_COL      = 640,
  parameter int ACTIVE_ROW      = 480,
  parameter int FRAMES_PER_MODE = 120,
  parameter int DEBOUNCE_CYC    = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  ColCount,
  input  logic [9:0]  RowCount,
  input  logic        btn_next,
  input  logic        auto_en,
  input  logic [11:0] pat0_rgb,
  input  logic [11:0] pat1_rgb,
  input  logic [11:0] pat2_rgb,
  input  logic [11:0] pat3_rgb,
  output logic [11:0] rgb,
  output logic [1:0]  mode,
  output logic        frame_start,
  output logic        pending
);

  localparam int DW =
    (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [9:0]    COL_LAST = 10'(TOTAL_COL - 1);
  localparam logic [9:0]    ROW_LAST = 10'(TOTAL_ROW - 1);
  localparam logic [9:0]    COL_ACT  = 10'(ACTIVE_COL);
  localparam logic [9:0]    ROW_ACT  = 10'(ACTIVE_ROW);
  localparam logic [7:0]    FPM_LAST = 8'(FRAMES_PER_MODE - 1);

  typedef enum logic [1:0] {
    RUN,
    PEND,
    SWITCH
  } state_t;

  state_t        state;
  logic          sync0;
  logic          sync1;
  logic          db_level;
  logic [DW-1:0] db_cnt;
  logic [7:0]    fcnt;
  logic [7:0]    fcnt_nx;
  logic          fwrap;
  logic          frame_end;
  logic          db_hit;
  logic          next_req;
  logic          auto_req;
  logic          active;
  logic [11:0]   pix_sel;

  assign frame_end = pix_en
                   && (ColCount == COL_LAST)
                   && (RowCount == ROW_LAST);

  // New level accepted on the Nth consecutive differing tick
  assign db_hit   = pix_en
                  && (sync1 != db_level)
                  && (db_cnt == DB_LAST);
  assign next_req = db_hit && sync1;

  assign fcnt_nx  = fcnt + 8'd1;
  assign fwrap    = (fcnt_nx >= FPM_LAST);
  assign auto_req = frame_end && auto_en && fwrap;

  assign active = (ColCount < COL_ACT)
               && (RowCount < ROW_ACT);

  always_comb begin
    pix_sel = pat0_rgb;
    unique case (mode)
      2'd0: pix_sel = pat0_rgb;
      2'd1: pix_sel = pat1_rgb;
      2'd2: pix_sel = pat2_rgb;
      2'd3: pix_sel = pat3_rgb;
      default: pix_sel = pat0_rgb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync0 <= btn_next;
      sync1 <= sync0;
      if (pix_en) begin
        if (sync1 == db_level) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_level <= sync1;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end
    end
  end

  // A commit restarts the count so each mode gets a full dwell
  always_ff @(posedge clk) begin
    if (reset || !auto_en) begin
      fcnt <= 8'd0;
    end else if (state == SWITCH) begin
      fcnt <= 8'd0;
    end else if (frame_end) begin
      if ((state == PEND) || fwrap) begin
        fcnt <= 8'd0;
      end else begin
        fcnt <= fcnt_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      mode        <= 2'd0;
      frame_start <= 1'b0;
      pending     <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          frame_start <= frame_end;
          if (next_req || auto_req) begin
            state   <= PEND;
            pending <= 1'b1;
          end
        end
        PEND: begin
          frame_start <= frame_end;
          if (frame_end) begin
            mode  <= mode + 2'd1;
            state <= SWITCH;
          end
        end
        SWITCH: begin
          frame_start <= 1'b0;
          pending     <= 1'b0;
          state       <= RUN;
        end
        default: begin
          frame_start <= 1'b0;
          pending     <= 1'b0;
          state       <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= 12'h000;
    end else if (pix_en) begin
      rgb <= active ? pix_sel : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Bench for vga_mode_sequencer: sparse scan of boundary positions,
// behavioural model compared every cycle plus directed literal checks.
module tb_vga_mode_sequencer;

  localparam int D    = 50;
  localparam int FPM  = 2;
  localparam int NPIX = 240;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        btn_next = 1'b0;
  logic        auto_en = 1'b0;
  logic [9:0]  col = 10'd0;
  logic [9:0]  row = 10'd0;
  logic [11:0] pat0, pat1, pat2, pat3;
  logic [11:0] rgb;
  logic [1:0]  mode;
  logic        frame_start;
  logic        pending;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int pi = NPIX - 1;
  int div = 0;
  int frames = 0;

  int cols [20] = '{0, 1, 2, 3, 4, 50, 100, 200, 319, 320,
                    500, 600, 637, 638, 639, 640, 641, 700, 798, 799};
  int rows [12] = '{0, 1, 2, 3, 239, 240, 477, 478, 479, 480,
                    523, 524};

  function automatic logic [11:0] pv(int n, int c, int r);
    logic [1:0] nb;
    logic [4:0] cb;
    logic [4:0] rb;
    nb = n[1:0];
    cb = c[4:0];
    rb = r[4:0];
    return {nb, cb, rb} ^ 12'h5A5;
  endfunction

  assign pat0 = pv(0, int'(col), int'(row));
  assign pat1 = pv(1, int'(col), int'(row));
  assign pat2 = pv(2, int'(col), int'(row));
  assign pat3 = pv(3, int'(col), int'(row));

  vga_mode_sequencer #(
    .TOTAL_COL(800),
    .TOTAL_ROW(525),
    .ACTIVE_COL(640),
    .ACTIVE_ROW(480),
    .FRAMES_PER_MODE(FPM),
    .DEBOUNCE_CYC(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .ColCount(col),
    .RowCount(row),
    .btn_next(btn_next),
    .auto_en(auto_en),
    .pat0_rgb(pat0),
    .pat1_rgb(pat1),
    .pat2_rgb(pat2),
    .pat3_rgb(pat3),
    .rgb(rgb),
    .mode(mode),
    .frame_start(frame_start),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Pixel tick every 4th clock; position walks the boundary table
  always @(posedge clk) begin
    #2;
    div = (div + 1) % 4;
    if (div == 0) begin
      pi  = (pi + 1) % NPIX;
      col = 10'(cols[pi % 20]);
      row = 10'(rows[pi / 20]);
      pix_en = 1'b1;
      if (pi == NPIX - 1) frames++;
    end else begin
      pix_en = 1'b0;
    end
  end

  // Behavioural model
  bit          m_h0 = 0, m_h1 = 0, m_deb = 0;
  int          m_run = 0, m_afc = 0;
  bit          m_sw = 0;
  logic        m_pending = 1'b0;
  logic        m_fs = 1'b0;
  logic [1:0]  m_mode = 2'd0;
  logic [11:0] m_rgb = 12'h000;

  always @(posedge clk) begin : model
    bit synced;
    bit fe;
    bit req;
    bit areq;
    if (reset) begin
      m_h0 = 0; m_h1 = 0; m_deb = 0; m_run = 0;
      m_afc = 0; m_sw = 0; m_pending = 1'b0;
      m_fs = 1'b0; m_mode = 2'd0; m_rgb = 12'h000;
    end else begin
      synced = m_h1;
      m_h1 = m_h0;
      m_h0 = btn_next;
      fe = pix_en && (col == 10'd799) && (row == 10'd524);
      req = 0;
      areq = 0;
      if (pix_en) begin
        if (synced != m_deb) begin
          m_run++;
          if (m_run == D) begin
            m_deb = synced;
            m_run = 0;
            req = synced;
          end
        end else begin
          m_run = 0;
        end
        m_rgb = (col < 10'd640 && row < 10'd480)
              ? pv(int'(m_mode), int'(col), int'(row)) : 12'h000;
      end
      if (!auto_en) m_afc = 0;
      m_fs = fe;
      if (m_sw) begin
        m_sw = 0;
        m_pending = 1'b0;
        m_afc = 0;
      end else if (m_pending) begin
        if (fe) begin
          m_mode = m_mode + 2'd1;
          m_sw = 1;
          m_afc = 0;
        end
      end else begin
        if (fe && auto_en) begin
          m_afc++;
          if (m_afc >= FPM - 1) begin
            areq = 1;
            m_afc = 0;
          end
        end
        if (req || areq) m_pending = 1'b1;
      end
    end
  end

  task automatic cmp(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("rgb", rgb, m_rgb);
      cmp("mode", 12'(mode), 12'(m_mode));
      cmp("frame_start", 12'(frame_start), 12'(m_fs));
      cmp("pending", 12'(pending), 12'(m_pending));
    end
  end

  task automatic wait_pi(input int target);
    int n = 0;
    while (!(pix_en && pi == target) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) cmp("wait_pi_timeout", 12'd1, 12'd0);
  endtask

  task automatic wait_frames(input int k);
    int t = frames + k;
    int n = 0;
    while (frames < t && n < k * 1000 + 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic wait_pending(input string nm);
    int n = 0;
    while (pending !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    cmp(nm, 12'(pending), 12'd1);
  endtask

  task automatic wait_mode_change(input logic [1:0] from,
                                  input string nm);
    int n = 0;
    while (mode === from && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) cmp(nm, 12'(mode), 12'(from + 2'd1));
  endtask

  logic [1:0] aseq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

  initial begin : scenario
    int lastf;
    logic [1:0] prev;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    cmp("reset_mode", 12'(mode), 12'd0);
    cmp("reset_pending", 12'(pending), 12'd0);
    cmp("reset_rgb", rgb, 12'h000);
    cmp("reset_frame_start", 12'(frame_start), 12'd0);
    reset = 1'b0;

    // Clean press mid-frame
    wait_pi(100);
    btn_next = 1'b1;
    wait_pending("press_pending");
    cmp("press_mode_before", 12'(mode), 12'd0);
    wait_mode_change(2'd0, "press_commit");
    cmp("press_mode", 12'(mode), 12'd1);
    cmp("press_frame_start", 12'(frame_start), 12'd1);
    cmp("press_at_frame_end", 12'(pi), 12'd239);
    wait_frames(2);
    cmp("hold_no_repeat", 12'(mode), 12'd1);
    btn_next = 1'b0;
    wait_frames(2);

    // Bounce then stable high
    for (int i = 0; i < 100; i++) begin
      btn_next = ~btn_next;
      repeat (40) @(negedge clk);
    end
    btn_next = 1'b1;
    wait_frames(3);
    cmp("bounce_mode", 12'(mode), 12'd2);
    btn_next = 1'b0;
    wait_frames(2);

    // Blanking and pattern selection with mode 2
    wait_pi(0);
    @(negedge clk);
    cmp("rgb_origin_mode2", rgb, 12'hDA5);
    wait_pi(15);
    @(negedge clk);
    cmp("rgb_col640", rgb, 12'h000);
    wait_pi(174);
    @(negedge clk);
    cmp("rgb_last_active", rgb, 12'hE5A);
    wait_pi(180);
    @(negedge clk);
    cmp("rgb_row480", rgb, 12'h000);

    // Two presses in one frame
    wait_pi(0);
    btn_next = 1'b1;
    repeat (220) @(negedge clk);
    btn_next = 1'b0;
    repeat (220) @(negedge clk);
    btn_next = 1'b1;
    repeat (220) @(negedge clk);
    btn_next = 1'b0;
    wait_frames(2);
    cmp("two_press_mode", 12'(mode), 12'd3);

    // Auto cycling
    reset = 1'b1;
    auto_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    prev = 2'd0;
    lastf = 0;
    for (int k = 0; k < 4; k++) begin
      wait_mode_change(prev, "auto_timeout");
      cmp($sformatf("auto_seq%0d", k), 12'(mode), 12'(aseq[k]));
      if (k > 0) cmp("auto_spacing", 12'(frames - lastf), 12'd2);
      lastf = frames;
      prev = mode;
      if (k == 3) auto_en = 1'b0;
    end
    wait_frames(2);
    cmp("auto_off_hold", 12'(mode), 12'd0);

    // Reset while a change is queued
    wait_pi(50);
    btn_next = 1'b1;
    wait_pending("pend_before_reset");
    btn_next = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp("reset_clears_pending", 12'(pending), 12'd0);
    cmp("reset_clears_mode", 12'(mode), 12'd0);
    reset = 1'b0;
    wait_frames(3);
    cmp("no_commit_after_reset", 12'(mode), 12'd0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
